// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - iterative signed multiply/divide unit with register write-back control
// One product/quotient bit per cycle; the pipeline is stalled while MULT or DIV is running.
module multdiv_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic [4:0]  rd,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        stall,
   output logic [4:0]  rd_out,
   output logic        write_rd,
   output logic        write_30,
   output logic [31:0] rstatus_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [5:0]  cnt;
   logic [63:0] mcand;
   logic [31:0] mplier;
   logic [63:0] acc;
   logic [63:0] addend;
   logic [63:0] acc_nxt;
   logic        mult_ovf;

   logic [31:0] rem;
   logic [31:0] quo;
   logic [31:0] divisor;
   logic [32:0] trial;
   logic [32:0] diff;
   logic        trial_ge;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;
   logic [31:0] quo_signed;
   logic        q_neg;
   logic        div_ovf;

   logic        op_div;
   logic        exc_reg;
   logic [4:0]  rd_cap;

   logic        accept;
   logic        start_mult;
   logic        start_div;
   logic        div_zero;
   logic        last_iter;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   assign accept     = (state == S_IDLE) || (state == S_DONE);
   assign start_mult = accept & ctrl_MULT;
   assign start_div  = accept & ~ctrl_MULT & ctrl_DIV;
   assign div_zero   = start_div & (data_operandB == 32'd0);
   assign last_iter  = (cnt == 6'd31);
   assign mag_a      = data_operandA[31] ? -data_operandA : data_operandA;
   assign mag_b      = data_operandB[31] ? -data_operandB : data_operandB;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (ctrl_MULT) begin
               state_nxt = S_MULT;
            end else if (ctrl_DIV) begin
               state_nxt = (data_operandB == 32'd0) ? S_DONE : S_DIV;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_MULT: begin
            if (last_iter) state_nxt = S_DONE;
         end
         S_DIV: begin
            if (last_iter) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit 31 of the multiplier carries weight -2^31, so the final step subtracts.
   always_comb begin
      addend = 64'd0;
      if (mplier[0]) begin
         addend = last_iter ? -mcand : mcand;
      end
      acc_nxt  = acc + addend;
      mult_ovf = (acc_nxt[63:32] != {32{acc_nxt[31]}});
   end

   always_comb begin
      trial      = {rem, quo[31]};
      diff       = trial - {1'b0, divisor};
      trial_ge   = ~diff[32];
      rem_nxt    = trial_ge ? diff[31:0] : trial[31:0];
      quo_nxt    = {quo[30:0], trial_ge};
      quo_signed = q_neg ? -quo_nxt : quo_nxt;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= 6'd0;
         mcand       <= 64'd0;
         mplier      <= 32'd0;
         acc         <= 64'd0;
         rem         <= 32'd0;
         quo         <= 32'd0;
         divisor     <= 32'd0;
         q_neg       <= 1'b0;
         div_ovf     <= 1'b0;
         op_div      <= 1'b0;
         exc_reg     <= 1'b0;
         rd_cap      <= 5'd0;
         rd_out      <= 5'd0;
         data_result <= 32'd0;
      end else if (start_mult) begin
         cnt    <= 6'd0;
         mcand  <= {{32{data_operandA[31]}}, data_operandA};
         mplier <= data_operandB;
         acc    <= 64'd0;
         rd_cap <= rd;
         op_div <= 1'b0;
      end else if (start_div) begin
         cnt     <= 6'd0;
         rem     <= 32'd0;
         quo     <= mag_a;
         divisor <= mag_b;
         q_neg   <= data_operandA[31] ^ data_operandB[31];
         div_ovf <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
         rd_cap  <= rd;
         op_div  <= 1'b1;
         // Divide by zero completes on this very edge.
         if (div_zero) begin
            data_result <= 32'd0;
            exc_reg     <= 1'b1;
            rd_out      <= rd;
         end
      end else if (state == S_MULT) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_nxt;
         cnt    <= last_iter ? 6'd0 : cnt + 6'd1;
         if (last_iter) begin
            data_result <= acc_nxt[31:0];
            exc_reg     <= mult_ovf;
            rd_out      <= rd_cap;
         end
      end else if (state == S_DIV) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
         cnt <= last_iter ? 6'd0 : cnt + 6'd1;
         if (last_iter) begin
            data_result <= quo_signed;
            exc_reg     <= div_ovf;
            rd_out      <= rd_cap;
         end
      end
   end

   always_comb begin
      stall          = (state == S_MULT) || (state == S_DIV);
      data_resultRDY = (state == S_DONE);
      data_exception = data_resultRDY & exc_reg;
      write_rd       = data_resultRDY & ~exc_reg & (rd_out != 5'd0);
      write_30       = data_resultRDY & exc_reg & (rd_out != 5'd0);
      rstatus_out    = 32'd0;
      if (write_30) begin
         rstatus_out = op_div ? 32'd5 : 32'd4;
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - self-checking bench for multdiv_ctrl
// Vector table, hand sequences for back-to-back and reset abort, and random ops against an arithmetic model.
module tb_multdiv_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [4:0]  rd;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        stall;
   logic [4:0]  rd_out;
   logic        write_rd;
   logic        write_30;
   logic [31:0] rstatus_out;

   int total = 0;
   int bad   = 0;

   multdiv_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .rd             (rd),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .stall          (stall),
      .rd_out         (rd_out),
      .write_rd       (write_rd),
      .write_30       (write_30),
      .rstatus_out    (rstatus_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          m;
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  r;
      logic [31:0] res;
      bit          exc;
      int          lat;
      bit          inject;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] r, input logic [31:0] res, input bit exc,
                                input int lat, input bit inject);
      vec_t v;
      v.m = m; v.d = d; v.a = a; v.b = b; v.r = r;
      v.res = res; v.exc = exc; v.lat = lat; v.inject = inject;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain signed arithmetic on 64-bit / 32-bit integers.
   task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output bit exc, output int lat);
      longint p;
      int     sa;
      int     sb;
      logic [31:0] lo;
      if (!is_div) begin
         p   = longint'($signed(a)) * longint'($signed(b));
         lo  = p[31:0];
         res = lo;
         exc = (p != longint'($signed(lo)));
         lat = 33;
      end else if (b == 32'd0) begin
         res = 32'd0; exc = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         res = 32'h8000_0000; exc = 1'b1; lat = 33;
      end else begin
         sa  = a;
         sb  = b;
         res = sa / sb;
         exc = 1'b0;
         lat = 33;
      end
   endtask

   // Drives a start pulse from mid-cycle, returns at the sample where RDY is seen.
   task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] eres, input bit eexc,
                        input int elat, input bit inject, input string tag);
      int edges;
      int stalls;
      bit ewr;
      bit ew30;
      ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b; rd = r;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      edges = 1; stalls = 0;
      while (!data_resultRDY && edges < 100) begin
         if (stall) stalls++;
         if (inject) begin
            if (edges == 10) begin
               ctrl_DIV = 1'b1; data_operandA = 32'd77; data_operandB = 32'd0; rd = 5'd0;
            end else begin
               ctrl_DIV = 1'b0;
            end
         end
         @(posedge clock); #1;
         edges++;
      end
      ctrl_DIV = 1'b0;
      ewr  = !eexc && (r != 5'd0);
      ew30 = eexc && (r != 5'd0);
      chk({tag, " latency"},   edges, elat);
      chk({tag, " stalls"},    stalls, elat - 1);
      chk({tag, " rdy"},       {31'd0, data_resultRDY}, 32'd1);
      chk({tag, " result"},    data_result, eres);
      chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, eexc});
      chk({tag, " rd_out"},    {27'd0, rd_out}, {27'd0, r});
      chk({tag, " write_rd"},  {31'd0, write_rd}, {31'd0, ewr});
      chk({tag, " write_30"},  {31'd0, write_30}, {31'd0, ew30});
      chk({tag, " rstatus"},   rstatus_out, ew30 ? (m ? 32'd4 : 32'd5) : 32'd0);
   endtask

   task automatic idle_check(input logic [31:0] eres, input logic [4:0] r, input string tag);
      @(posedge clock); #1;
      chk({tag, " rdy one cycle"}, {31'd0, data_resultRDY}, 32'd0);
      chk({tag, " idle stall"},    {31'd0, stall}, 32'd0);
      chk({tag, " result hold"},   data_result, eres);
      chk({tag, " rd_out hold"},   {27'd0, rd_out}, {27'd0, r});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " stall"},     {31'd0, stall}, 32'd0);
      chk({tag, " rdy"},       {31'd0, data_resultRDY}, 32'd0);
      chk({tag, " exception"}, {31'd0, data_exception}, 32'd0);
      chk({tag, " result"},    data_result, 32'd0);
      chk({tag, " rd_out"},    {27'd0, rd_out}, 32'd0);
      chk({tag, " write_rd"},  {31'd0, write_rd}, 32'd0);
      chk({tag, " write_30"},  {31'd0, write_30}, 32'd0);
      chk({tag, " rstatus"},   rstatus_out, 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] eres;
      logic [4:0]  rr;
      bit          rm;
      bit          eexc;
      int          elat;
      int          t;
      int          edges;

      reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      data_operandA = 32'd0; data_operandB = 32'd0; rd = 5'd0;
      repeat (2) @(posedge clock);
      #1;
      chk_all_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      vecs.push_back(mkv(1, 0, 32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, 33, 0));
      vecs.push_back(mkv(1, 0, 32'h0001_0000,  32'h0001_0000, 5'd9, 32'h0000_0000, 1, 33, 0));
      vecs.push_back(mkv(0, 1, 32'hFFFF_FFF9,  32'd2,         5'd3, 32'hFFFF_FFFD, 0, 33, 0));
      vecs.push_back(mkv(0, 1, 32'd5,          32'd0,         5'd3, 32'h0000_0000, 1, 1,  0));
      vecs.push_back(mkv(0, 1, 32'd5,          32'd0,         5'd0, 32'h0000_0000, 1, 1,  0));
      vecs.push_back(mkv(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1, 33, 0));
      vecs.push_back(mkv(1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 5'd1, 32'h8000_0000, 1, 33, 0));
      vecs.push_back(mkv(1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 32'h0000_0001, 0, 33, 0));
      vecs.push_back(mkv(0, 1, 32'd7,          32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 0, 33, 0));
      vecs.push_back(mkv(0, 1, 32'd0,          32'd5,         5'd6, 32'h0000_0000, 0, 33, 0));
      vecs.push_back(mkv(1, 0, 32'h7FFF_FFFF,  32'd2,         5'd8, 32'hFFFF_FFFE, 1, 33, 0));
      vecs.push_back(mkv(1, 1, 32'd6,          32'd3,         5'd2, 32'd18,        0, 33, 1));

      foreach (vecs[i]) begin
         do_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].r,
               vecs[i].res, vecs[i].exc, vecs[i].lat, vecs[i].inject, $sformatf("vec%0d", i));
         idle_check(vecs[i].res, vecs[i].r, $sformatf("vec%0d", i));
      end

      // Back-to-back: divide started in the DONE cycle of a multiply.
      do_op(1, 0, 32'd2, 32'd2, 5'd11, 32'd4, 0, 33, 0, "b2b mult");
      do_op(0, 1, 32'd100, 32'd10, 5'd12, 32'd10, 0, 33, 0, "b2b div");
      idle_check(32'd10, 5'd12, "b2b");

      // Reset at iteration 15 aborts the multiply without a result pulse.
      ctrl_MULT = 1'b1; data_operandA = 32'h1234; data_operandB = 32'h5678; rd = 5'd6;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      edges = 1;
      while (edges < 16) begin
         @(posedge clock); #1;
         edges++;
      end
      chk("abort busy stall", {31'd0, stall}, 32'd1);
      reset = 1'b1;
      #1;
      chk_all_zero("abort async");
      repeat (3) begin
         @(posedge clock); #1;
         chk("abort hold rdy", {31'd0, data_resultRDY}, 32'd0);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
         chk("after abort rdy",   {31'd0, data_resultRDY}, 32'd0);
         chk("after abort stall", {31'd0, stall}, 32'd0);
      end
      do_op(1, 0, 32'd1, 32'd1, 5'd1, 32'd1, 0, 33, 0, "post reset");
      idle_check(32'd1, 5'd1, "post reset");

      for (int n = 0; n < 40; n++) begin
         rm = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin
               t = int'($urandom_range(0, 200)) - 100; ra = t;
               t = int'($urandom_range(0, 200)) - 100; rb = t;
            end
            2: begin ra = $urandom; t = int'($urandom_range(0, 20)) - 10; rb = t; end
            default: begin ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF; rb = $urandom; end
         endcase
         if (!rm && $urandom_range(0, 7) == 0) rb = 32'd0;
         rr = 5'($urandom_range(0, 31));
         model(!rm, ra, rb, eres, eexc, elat);
         do_op(rm, !rm, ra, rb, rr, eres, eexc, elat, 0, $sformatf("rand%0d", n));
         idle_check(eres, rr, $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
